// File: rtl/imm_gen_pkg.sv
// Shared opcode constants and immediate-format codes for the RV32I/RV64I immediate generator.
// Used by imm_decode, imm_gen_pipe and downstream execute logic.
package imm_gen_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPC_W   = 7;
  localparam int unsigned FMT_W   = 3;

  localparam logic [OPC_W-1:0] OPC_LOAD      = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [OPC_W-1:0] OPC_STORE     = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_LUI       = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JALR      = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_JAL       = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM    = 7'b1110011;

  typedef enum logic [FMT_W-1:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_ZIMM  = 3'd7
  } imm_fmt_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational instruction -> {immediate, format} decoder at XLEN width.
// Optional CSR-immediate decode is enabled by defining IMM_GEN_ZICSR_EN.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INSTR_W-1:0] instr_i,
  output logic [XLEN-1:0]    imm_o,
  output imm_fmt_e           fmt_o
);

  localparam int unsigned SHAMT_W = (XLEN == 64) ? 6 : 5;

  logic [OPC_W-1:0] opcode;
  logic [2:0]       funct3;
  logic             is_shift;

  assign opcode   = instr_i[6:0];
  assign funct3   = instr_i[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Signed forms: pre-fill with the sign bit, then overwrite the low field.
  always_comb begin
    imm_o = '0;
    fmt_o = FMT_NONE;
    case (opcode)
      OPC_LOAD, OPC_JALR: begin
        imm_o       = {XLEN{instr_i[31]}};
        imm_o[11:0] = instr_i[31:20];
        fmt_o       = FMT_I;
      end
      OPC_OP_IMM: begin
        if (is_shift) begin
          imm_o[SHAMT_W-1:0] = instr_i[20 +: SHAMT_W];
          fmt_o              = FMT_SHAMT;
        end else begin
          imm_o       = {XLEN{instr_i[31]}};
          imm_o[11:0] = instr_i[31:20];
          fmt_o       = FMT_I;
        end
      end
      OPC_OP_IMM_32: begin
        if (XLEN == 64) begin
          if (is_shift) begin
            imm_o[4:0] = instr_i[24:20];
            fmt_o      = FMT_SHAMT;
          end else begin
            imm_o       = {XLEN{instr_i[31]}};
            imm_o[11:0] = instr_i[31:20];
            fmt_o       = FMT_I;
          end
        end
      end
      OPC_STORE: begin
        imm_o       = {XLEN{instr_i[31]}};
        imm_o[11:0] = {instr_i[31:25], instr_i[11:7]};
        fmt_o       = FMT_S;
      end
      OPC_BRANCH: begin
        imm_o       = {XLEN{instr_i[31]}};
        imm_o[12:0] = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
        fmt_o       = FMT_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm_o       = {XLEN{instr_i[31]}};
        imm_o[31:0] = {instr_i[31:12], 12'b0};
        fmt_o       = FMT_U;
      end
      OPC_JAL: begin
        imm_o       = {XLEN{instr_i[31]}};
        imm_o[20:0] = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
        fmt_o       = FMT_J;
      end
`ifdef IMM_GEN_ZICSR_EN
      OPC_SYSTEM: begin
        if (funct3[2]) begin
          imm_o[4:0] = instr_i[19:15];
          fmt_o      = FMT_ZIMM;
        end
      end
`endif
      default: begin
        imm_o = '0;
        fmt_o = FMT_NONE;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Stage-2 immediate generator: input-side decode feeding a main + skid register pair
// with valid/ready handshake. IMM_GEN_ZICSR_EN enables CSR-immediate decode.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_imm,
  output logic [FMT_W-1:0]   out_fmt,
  output logic [TAG_W-1:0]   out_tag
);

  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr_i (in_instr),
    .imm_o   (dec_imm),
    .fmt_o   (dec_fmt)
  );

  logic            main_valid_q, main_valid_d;
  logic [XLEN-1:0] main_imm_q,   main_imm_d;
  imm_fmt_e        main_fmt_q,   main_fmt_d;
  logic [TAG_W-1:0] main_tag_q,  main_tag_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_imm_q,   skid_imm_d;
  imm_fmt_e        skid_fmt_q,   skid_fmt_d;
  logic [TAG_W-1:0] skid_tag_q,  skid_tag_d;
  logic            in_ready_q,   in_ready_d;
  logic            accept_c, drain_c;

  // Skid refills main first so ordering stays FIFO; in_ready only depends on the next skid state.
  always_comb begin
    main_valid_d = main_valid_q;
    main_imm_d   = main_imm_q;
    main_fmt_d   = main_fmt_q;
    main_tag_d   = main_tag_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_fmt_d   = skid_fmt_q;
    skid_tag_d   = skid_tag_q;
    accept_c     = in_valid & in_ready_q;
    drain_c      = main_valid_q & out_ready;

    if (skid_valid_q) begin
      if (drain_c) begin
        main_imm_d   = skid_imm_q;
        main_fmt_d   = skid_fmt_q;
        main_tag_d   = skid_tag_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept_c) begin
      if (!main_valid_q || drain_c) begin
        main_valid_d = 1'b1;
        main_imm_d   = dec_imm;
        main_fmt_d   = dec_fmt;
        main_tag_d   = in_tag;
      end else begin
        skid_valid_d = 1'b1;
        skid_imm_d   = dec_imm;
        skid_fmt_d   = dec_fmt;
        skid_tag_d   = in_tag;
      end
    end else if (drain_c) begin
      main_valid_d = 1'b0;
    end

    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= '0;
      main_fmt_q   <= FMT_NONE;
      main_tag_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= FMT_NONE;
      skid_tag_q   <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_imm_q   <= main_imm_d;
      main_fmt_q   <= main_fmt_d;
      main_tag_q   <= main_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_fmt_q   <= skid_fmt_d;
      skid_tag_q   <= skid_tag_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_imm   = main_imm_q;
  assign out_fmt   = main_fmt_q;
  assign out_tag   = main_tag_q;

endmodule
